// File: rtl/bubble_seq_pkg.sv
// Shared state encoding and default geometry for the bubble access sequencer.
package bubble_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEEK,
      READ,
      STOP,
      DONE
   } seq_state_t;

   localparam int DEF_POS_W          = 12;
   localparam int DEF_LOOP_LENGTH    = 2053;
   localparam int DEF_BOOT_LENGTH    = 2053;
   localparam int DEF_READ_POSITIONS = 584;
   localparam int DEF_SETUP_CYCLES   = 16;
   localparam int DEF_STOP_TIMEOUT   = 1023;

endpackage

// File: rtl/bubble_position_counter.sv
// Rising-edge detector on position_change feeding a position counter that
// wraps from LENGTH-1 back to 0. Only counts while count_en is high.
module bubble_position_counter #(
   parameter int POS_W  = 12,
   parameter int LENGTH = 2053
) (
   input  logic             master_clock,
   input  logic             reset,
   input  logic             position_change,
   input  logic             count_en,
   output logic             tick,
   output logic [POS_W-1:0] position
);

   localparam logic [POS_W-1:0] LAST = POS_W'(LENGTH - 1);

   logic change_d;

   // Previous position_change level, for rising-edge detection.
   always_ff @(posedge master_clock) begin
      if (reset) change_d <= 1'b0;
      else       change_d <= position_change;
   end

   assign tick = position_change & ~change_d;

   // Advance the position once per detected edge, wrapping at the loop end.
   always_ff @(posedge master_clock) begin
      if (reset) begin
         position <= '0;
      end else if (tick && count_en) begin
         position <= (position == LAST) ? '0 : position + 1'b1;
      end
   end

endmodule

// File: rtl/bubble_access_sequencer.sv
// Page-access sequencer for the bubble timing generator: seek to the target
// position, replicate for a fixed number of positions, stop the coils and
// report completion (with an error flag on abort, bad target or timeout).
module bubble_access_sequencer
   import bubble_seq_pkg::*;
#(
   parameter int POS_W          = DEF_POS_W,
   parameter int LOOP_LENGTH    = DEF_LOOP_LENGTH,
   parameter int BOOT_LENGTH    = DEF_BOOT_LENGTH,
   parameter int READ_POSITIONS = DEF_READ_POSITIONS,
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int STOP_TIMEOUT   = DEF_STOP_TIMEOUT
) (
   input  logic             master_clock,
   input  logic             reset,
   input  logic             bubble_module_enable,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [POS_W-1:0] req_page,
   input  logic             req_bootloop,
   input  logic             position_change,
   input  logic             coil_enable,
   output logic             bubble_shift_enable,
   output logic             replicator_enable,
   output logic             bootloop_enable,
   output logic [POS_W-1:0] user_position,
   output logic [POS_W-1:0] boot_position,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
   localparam int STOP_W  = $clog2(STOP_TIMEOUT + 1);

   localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
   localparam logic [STOP_W-1:0]  STOP_LAST  = STOP_W'(STOP_TIMEOUT - 1);
   localparam logic [POS_W-1:0]   READ_TOTAL = POS_W'(READ_POSITIONS);
   localparam logic [POS_W:0]     LOOP_LIMIT = (POS_W + 1)'(LOOP_LENGTH);
   localparam logic [POS_W:0]     BOOT_LIMIT = (POS_W + 1)'(BOOT_LENGTH);

   seq_state_t         state, state_next;
   logic [POS_W-1:0]   target, target_next;
   logic               boot_sel, boot_next;
   logic               err_flag, err_next;
   logic [SETUP_W-1:0] setup_cnt, setup_next;
   logic [POS_W-1:0]   read_cnt, read_next, read_sum;
   logic [STOP_W-1:0]  stop_cnt, stop_next;

   logic               user_tick, boot_tick, pos_tick;
   logic [POS_W-1:0]   sel_pos;
   logic               bad_target;

   bubble_position_counter #(
      .POS_W  (POS_W),
      .LENGTH (LOOP_LENGTH)
   ) user_counter (
      .master_clock    (master_clock),
      .reset           (reset),
      .position_change (position_change),
      .count_en        (~bootloop_enable),
      .tick            (user_tick),
      .position        (user_position)
   );

   bubble_position_counter #(
      .POS_W  (POS_W),
      .LENGTH (BOOT_LENGTH)
   ) boot_counter (
      .master_clock    (master_clock),
      .reset           (reset),
      .position_change (position_change),
      .count_en        (bootloop_enable),
      .tick            (boot_tick),
      .position        (boot_position)
   );

   // Both detectors see the same input, so either edge is the position tick.
   assign pos_tick   = user_tick | boot_tick;
   assign sel_pos    = boot_sel ? boot_position : user_position;
   assign bad_target = boot_sel ? ({1'b0, target} >= BOOT_LIMIT)
                                : ({1'b0, target} >= LOOP_LIMIT);
   assign read_sum   = read_cnt + {{(POS_W - 1){1'b0}}, pos_tick};

   assign req_ready           = (state == IDLE) && !bubble_module_enable;
   assign busy                = (state != IDLE);
   assign done                = (state == DONE);
   assign error               = (state == DONE) && err_flag;
   // A bad target passes through SEEK for one cycle; keep the coils off then.
   assign bubble_shift_enable = !(((state == SEEK) && !bad_target) || (state == READ));
   assign replicator_enable   = (state != READ);
   assign bootloop_enable     = boot_sel && ((state == SETUP) || (state == SEEK) ||
                                             (state == READ)  || (state == STOP));

   // State register plus request latch and per-phase counters.
   always_ff @(posedge master_clock) begin
      if (reset) begin
         state     <= IDLE;
         boot_sel  <= 1'b0;
         err_flag  <= 1'b0;
         setup_cnt <= '0;
         read_cnt  <= '0;
         stop_cnt  <= '0;
      end else begin
         state     <= state_next;
         boot_sel  <= boot_next;
         err_flag  <= err_next;
         setup_cnt <= setup_next;
         read_cnt  <= read_next;
         stop_cnt  <= stop_next;
      end
      target <= target_next;
   end

   // Next-state logic; phase counters idle at zero outside their own state.
   always_comb begin
      state_next  = state;
      target_next = target;
      boot_next   = boot_sel;
      err_next    = err_flag;
      setup_next  = '0;
      read_next   = '0;
      stop_next   = '0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               target_next = req_page;
               boot_next   = req_bootloop;
               err_next    = 1'b0;
               state_next  = SETUP;
            end
         end
         SETUP: begin
            if (bubble_module_enable) begin
               err_next   = 1'b1;
               state_next = STOP;
            end else if (setup_cnt == SETUP_LAST) begin
               state_next = SEEK;
            end else begin
               setup_next = setup_cnt + 1'b1;
            end
         end
         SEEK: begin
            if (bubble_module_enable) begin
               err_next   = 1'b1;
               state_next = STOP;
            end else if (bad_target) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else if (sel_pos == target) begin
               // A tick landing on the transition cycle belongs to READ.
               read_next  = {{(POS_W - 1){1'b0}}, pos_tick};
               state_next = READ;
            end
         end
         READ: begin
            if (bubble_module_enable) begin
               err_next   = 1'b1;
               state_next = STOP;
            end else if (read_sum == READ_TOTAL) begin
               state_next = STOP;
            end else begin
               read_next = read_sum;
            end
         end
         STOP: begin
            if (coil_enable) begin
               state_next = DONE;
            end else if (stop_cnt == STOP_LAST) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               stop_next = stop_cnt + 1'b1;
            end
         end
         DONE: begin
            boot_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Self-checking bench for bubble_access_sequencer: table of access scenarios
// plus hand-written reset, gating and mid-operation reset sequences.
module tb_bubble_access_sequencer;

   localparam int POS_W     = 12;
   localparam int LOOP_LEN  = 2053;
   localparam int BOOT_LEN  = 2053;
   localparam int READ_POS  = 584;
   localparam int SETUP_CYC = 16;
   localparam int STOP_TO   = 1023;

   typedef enum int {M_NORMAL, M_BAD, M_ABORT, M_TIMEOUT} mode_t;

   typedef struct {
      int    pre_to;   // user position to reach in IDLE first (-1: none)
      int    page;
      bit    boot;
      mode_t mode;
      bit    exp_err;
   } vec_t;

   logic             master_clock = 1'b0;
   logic             reset;
   logic             bubble_module_enable;
   logic             req_valid;
   logic             req_ready;
   logic [POS_W-1:0] req_page;
   logic             req_bootloop;
   logic             position_change;
   logic             coil_enable;
   logic             bubble_shift_enable;
   logic             replicator_enable;
   logic             bootloop_enable;
   logic [POS_W-1:0] user_position;
   logic [POS_W-1:0] boot_position;
   logic             busy;
   logic             done;
   logic             error;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_err_q[$];
   int model_user = 0;
   int model_boot = 0;
   vec_t tbl[6];

   always #5 master_clock = ~master_clock;

   bubble_access_sequencer #(
      .POS_W          (POS_W),
      .LOOP_LENGTH    (LOOP_LEN),
      .BOOT_LENGTH    (BOOT_LEN),
      .READ_POSITIONS (READ_POS),
      .SETUP_CYCLES   (SETUP_CYC),
      .STOP_TIMEOUT   (STOP_TO)
   ) dut (
      .master_clock         (master_clock),
      .reset                (reset),
      .bubble_module_enable (bubble_module_enable),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_page             (req_page),
      .req_bootloop         (req_bootloop),
      .position_change      (position_change),
      .coil_enable          (coil_enable),
      .bubble_shift_enable  (bubble_shift_enable),
      .replicator_enable    (replicator_enable),
      .bootloop_enable      (bootloop_enable),
      .user_position        (user_position),
      .boot_position        (boot_position),
      .busy                 (busy),
      .done                 (done),
      .error                (error)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One position: 8 cycles high, 2 low. Called and returns on a negedge.
   task automatic pulse();
      position_change = 1'b1;
      repeat (8) @(negedge master_clock);
      position_change = 1'b0;
      repeat (2) @(negedge master_clock);
   endtask

   task automatic advance(input bit boot);
      if (boot) model_boot = (model_boot + 1) % BOOT_LEN;
      else      model_user = (model_user + 1) % LOOP_LEN;
   endtask

   function automatic int cur_pos(input bit boot);
      return boot ? int'(boot_position) : int'(user_position);
   endfunction

   task automatic run_access(input vec_t v);
      int n;
      int cnt;
      int len;
      int exp_seek;
      bit seen;
      cnt = 0;
      while (v.pre_to >= 0 && model_user != v.pre_to && cnt < LOOP_LEN) begin
         pulse();
         advance(1'b0);
         cnt++;
      end
      check("idle_user_pos", int'(user_position), model_user);
      coil_enable          = 1'b0;
      bubble_module_enable = 1'b0;
      check("ready_idle", int'(req_ready), 1);
      req_valid    = 1'b1;
      req_page     = POS_W'(v.page);
      req_bootloop = v.boot;
      @(negedge master_clock);
      req_valid = 1'b0;
      exp_err_q.push_back(v.exp_err);
      check("busy_after_accept", int'(busy), 1);
      check("bootloop_in_setup", int'(bootloop_enable), int'(v.boot));
      if (v.mode == M_BAD) begin
         seen = 1'b0;
         n = 0;
         while (!done && n < 40) begin
            if (!bubble_shift_enable) seen = 1'b1;
            @(negedge master_clock);
            n++;
         end
         check("bad_page_shift_seen", int'(seen), 0);
      end else begin
         n = 0;
         while (bubble_shift_enable && n < 64) begin
            @(negedge master_clock);
            n++;
         end
         check("setup_cycles", n, SETUP_CYC);
         check("bootloop_at_shift", int'(bootloop_enable), int'(v.boot));
         len      = v.boot ? BOOT_LEN : LOOP_LEN;
         exp_seek = (v.page - (v.boot ? model_boot : model_user) + len) % len;
         repeat (2) @(negedge master_clock);
         cnt = 0;
         while (replicator_enable && cnt < len + 2) begin
            pulse();
            advance(v.boot);
            cnt++;
            check("seek_pos", cur_pos(v.boot), v.boot ? model_boot : model_user);
         end
         check("seek_ticks", cnt, exp_seek);
         check("shift_in_read", int'(bubble_shift_enable), 0);
         if (v.mode == M_NORMAL) begin
            cnt = 0;
            while (!replicator_enable && cnt < READ_POS + 20) begin
               pulse();
               advance(v.boot);
               cnt++;
            end
            check("read_ticks", cnt, READ_POS);
            check("shift_off_in_stop", int'(bubble_shift_enable), 1);
         end else begin
            repeat ((v.mode == M_ABORT) ? 50 : 0) begin
               pulse();
               advance(v.boot);
            end
            bubble_module_enable = 1'b1;
            @(negedge master_clock);
            check("abort_shift_off", int'(bubble_shift_enable), 1);
            check("abort_rep_off", int'(replicator_enable), 1);
         end
         if (v.mode == M_TIMEOUT) begin
            n = 0;
            while (!done && n < STOP_TO + 50) begin
               @(negedge master_clock);
               n++;
            end
            check("stop_timeout_cycles", n, STOP_TO);
         end else begin
            repeat (3) @(negedge master_clock);
            check("done_waits_for_coil", int'(done), 0);
            coil_enable = 1'b1;
            @(negedge master_clock);
         end
      end
      check("done_seen", int'(done), 1);
      if (done && exp_err_q.size() > 0) check("error_flag", int'(error), int'(exp_err_q.pop_front()));
      @(negedge master_clock);
      check("done_one_cycle", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
      check("bootloop_off_idle", int'(bootloop_enable), 0);
      bubble_module_enable = 1'b0;
      check("user_pos_end", int'(user_position), model_user);
      check("boot_pos_end", int'(boot_position), model_boot);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{pre_to: -1,   page: 10,   boot: 1'b0, mode: M_NORMAL,  exp_err: 1'b0};
      tbl[1] = '{pre_to: 2050, page: 1,    boot: 1'b0, mode: M_NORMAL,  exp_err: 1'b0};
      tbl[2] = '{pre_to: -1,   page: 0,    boot: 1'b1, mode: M_NORMAL,  exp_err: 1'b0};
      tbl[3] = '{pre_to: -1,   page: 3000, boot: 1'b0, mode: M_BAD,     exp_err: 1'b1};
      tbl[4] = '{pre_to: 600,  page: 600,  boot: 1'b0, mode: M_ABORT,   exp_err: 1'b1};
      tbl[5] = '{pre_to: 700,  page: 700,  boot: 1'b0, mode: M_TIMEOUT, exp_err: 1'b1};

      reset                = 1'b1;
      req_valid            = 1'b1;
      req_page             = POS_W'(10);
      req_bootloop         = 1'b0;
      bubble_module_enable = 1'b0;
      position_change      = 1'b0;
      coil_enable          = 1'b1;
      repeat (3) @(negedge master_clock);
      check("rst_shift", int'(bubble_shift_enable), 1);
      check("rst_rep", int'(replicator_enable), 1);
      check("rst_bootloop", int'(bootloop_enable), 0);
      check("rst_user_pos", int'(user_position), 0);
      check("rst_boot_pos", int'(boot_position), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      reset     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("ready_after_reset", int'(req_ready), 1);
      @(negedge master_clock);
      check("no_accept_without_valid", int'(busy), 0);

      bubble_module_enable = 1'b1;
      req_valid            = 1'b1;
      repeat (3) @(negedge master_clock);
      check("ready_blocked", int'(req_ready), 0);
      check("busy_blocked", int'(busy), 0);
      req_valid            = 1'b0;
      bubble_module_enable = 1'b0;
      @(negedge master_clock);

      for (int i = 0; i < 6; i++) run_access(tbl[i]);

      req_valid    = 1'b1;
      req_page     = POS_W'(5);
      req_bootloop = 1'b1;
      @(negedge master_clock);
      req_valid = 1'b0;
      repeat (4) @(negedge master_clock);
      check("midop_bootloop_on", int'(bootloop_enable), 1);
      reset = 1'b1;
      @(negedge master_clock);
      check("midop_rst_bootloop", int'(bootloop_enable), 0);
      check("midop_rst_busy", int'(busy), 0);
      check("midop_rst_shift", int'(bubble_shift_enable), 1);
      check("midop_rst_user_pos", int'(user_position), 0);
      check("midop_rst_boot_pos", int'(boot_position), 0);
      reset = 1'b0;
      @(negedge master_clock);
      check("midop_no_done", int'(done), 0);
      check("queue_empty", exp_err_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
